// File: rtl/xdma_beat_tracker.sv
// -----------------------------------------------------------------------------
// xdma_beat_tracker
//
// Transfer-tracking stage behind the XDMA request manager. Each granted beat
// passes through a single full-throughput output register. The block counts
// accepted and delivered beats, flags the final beat with oup_last_o, and
// pulses done_o for one cycle when the transfer has completed.
//
// Optional feature macro: XDMA_BEAT_TRACKER_STALL_CNT_EN
//   defined   -> stall_cnt_o counts RUN cycles in which downstream stalls a
//                valid beat. It saturates at all-ones and is cleared on an
//                accepted start.
//   undefined -> no counter is built and stall_cnt_o is tied to zero.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle pulse that starts a transfer (honoured in IDLE only)
//   len_i        transfer length in beats, sampled together with start_i
//   inp_data_i   upstream beat payload
//   inp_valid_i  upstream valid
//   inp_ready_o  upstream ready
//   oup_data_o   registered beat payload
//   oup_valid_o  downstream valid
//   oup_ready_i  downstream ready
//   oup_last_o   final beat of the transfer
//   done_o       one-cycle completion pulse
//   busy_o       transfer in progress, including the done cycle
//   beat_cnt_o   beats handed downstream in the current transfer
//   stall_cnt_o  downstream stall cycles (zero unless the feature is built)
// -----------------------------------------------------------------------------
module xdma_beat_tracker #(
  parameter type         data_t    = logic,
  parameter int unsigned LEN_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  data_t                inp_data_i,
  input  logic                 inp_valid_i,
  output logic                 inp_ready_o,
  output data_t                oup_data_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i,
  output logic                 oup_last_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [LEN_WIDTH-1:0] beat_cnt_o,
  output logic [31:0]          stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_r;
  state_e               state_d_s;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] acc_r;
  logic [LEN_WIDTH-1:0] beat_cnt_r;
  data_t                data_r;
  logic                 valid_r;

  logic                 start_acc_s;
  logic                 inp_hs_s;
  logic                 out_hs_s;
  logic                 last_s;
  logic                 inp_ready_s;

  // A start is only honoured from IDLE; later pulses leave the transfer alone.
  assign start_acc_s = start_i && (state_r == ST_IDLE);

  // Accept only while beats remain and the output slot is free or draining
  // this cycle, which keeps the single register at one beat per cycle.
  assign inp_ready_s = (state_r == ST_RUN) && (acc_r != len_r) &&
                       (!valid_r || oup_ready_i);
  assign inp_hs_s    = inp_valid_i && inp_ready_s;
  assign out_hs_s    = (state_r == ST_RUN) && valid_r && oup_ready_i;
  assign last_s      = valid_r && (beat_cnt_r == (len_r - LEN_WIDTH'(1)));

  assign inp_ready_o = inp_ready_s;
  assign oup_data_o  = data_r;
  assign oup_valid_o = valid_r;
  assign oup_last_o  = last_s;
  assign done_o      = (state_r == ST_DONE);
  assign busy_o      = (state_r != ST_IDLE);
  assign beat_cnt_o  = beat_cnt_r;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_d_s;
    end
  end

  // FSM next-state logic; a zero-length transfer goes straight to DONE.
  always_comb begin
    state_d_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == {LEN_WIDTH{1'b0}}) begin
            state_d_s = ST_DONE;
          end else begin
            state_d_s = ST_RUN;
          end
        end else begin
          state_d_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (out_hs_s && last_s) begin
          state_d_s = ST_DONE;
        end else begin
          state_d_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d_s = ST_IDLE;
      end
      default: begin
        state_d_s = ST_IDLE;
      end
    endcase
  end

  // Length capture, beat counters and the output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_r      <= {LEN_WIDTH{1'b0}};
      acc_r      <= {LEN_WIDTH{1'b0}};
      beat_cnt_r <= {LEN_WIDTH{1'b0}};
      data_r     <= '0;
      valid_r    <= 1'b0;
    end else if (start_acc_s) begin
      len_r      <= len_i;
      acc_r      <= {LEN_WIDTH{1'b0}};
      beat_cnt_r <= {LEN_WIDTH{1'b0}};
      data_r     <= '0;
      valid_r    <= 1'b0;
    end else if (state_r == ST_RUN) begin
      // A load wins over an unload so a simultaneous pair keeps valid high.
      if (inp_hs_s) begin
        acc_r   <= acc_r + LEN_WIDTH'(1);
        data_r  <= inp_data_i;
        valid_r <= 1'b1;
      end else if (out_hs_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (out_hs_s) begin
        beat_cnt_r <= beat_cnt_r + LEN_WIDTH'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef XDMA_BEAT_TRACKER_STALL_CNT_EN
  logic [31:0] stall_r;

  // Saturating count of RUN cycles where a valid beat is held by downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_r <= 32'd0;
    end else if (start_acc_s) begin
      stall_r <= 32'd0;
    end else if ((state_r == ST_RUN) && valid_r && !oup_ready_i &&
                 (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt_o = stall_r;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_xdma_beat_tracker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for xdma_beat_tracker. A per-cycle vector table covers
// streaming, zero-length and ignored-restart behaviour; hand-written sequences
// cover length limiting, downstream stalls and reset in mid-transfer.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_xdma_beat_tracker;

  localparam int LW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic [7:0]    inp_data_i;
  logic          inp_valid_i;
  logic          inp_ready_o;
  logic [7:0]    oup_data_o;
  logic          oup_valid_o;
  logic          oup_ready_i;
  logic          oup_last_o;
  logic          done_o;
  logic          busy_o;
  logic [LW-1:0] beat_cnt_o;
  logic [31:0]   stall_cnt_o;

  xdma_beat_tracker #(.data_t(logic [7:0]), .LEN_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .inp_data_i(inp_data_i), .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o),
    .oup_data_o(oup_data_o), .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i),
    .oup_last_o(oup_last_o), .done_o(done_o), .busy_o(busy_o),
    .beat_cnt_o(beat_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       start;
    logic [7:0] len;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_irdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_last;
    logic       e_done;
    logic       e_busy;
    logic [7:0] e_cnt;
  } vec_t;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] l, input logic iv,
                              input logic [7:0] id, input logic ordy, input logic irdy,
                              input logic ov, input logic [7:0] od, input logic last,
                              input logic dn, input logic bsy, input logic [7:0] cnt);
    vec_t v;
    v.start = s;  v.len = l;   v.iv = iv;      v.id = id;       v.ordy = ordy;
    v.e_irdy = irdy; v.e_ov = ov; v.e_od = od; v.e_last = last;
    v.e_done = dn;   v.e_busy = bsy; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic logic [63:0] outs();
    return {43'd0, inp_ready_o, oup_valid_o, oup_data_o, oup_last_o, done_o, busy_o, beat_cnt_o};
  endfunction

  vec_t tbl[18];

  initial begin
    int up;
    int dn;
    int ndone;
    logic seen;
    logic [31:0] exp_stall;

    rst_ni = 1'b0; start_i = 1'b0; len_i = 8'd0; inp_data_i = 8'd0;
    inp_valid_i = 1'b0; oup_ready_i = 1'b0;

    //              st len  iv id     ordy | irdy ov  od     last dn  bsy cnt
    tbl[0]  = mk(1'b1, 8'd4, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    tbl[1]  = mk(1'b0, 8'd0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0);
    tbl[2]  = mk(1'b0, 8'd0, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'd0);
    tbl[3]  = mk(1'b0, 8'd0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'd1);
    tbl[4]  = mk(1'b0, 8'd0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'd2);
    tbl[5]  = mk(1'b0, 8'd0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 8'd3);
    tbl[6]  = mk(1'b0, 8'd0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA4, 1'b0, 1'b1, 1'b1, 8'd4);
    tbl[7]  = mk(1'b0, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA4, 1'b0, 1'b0, 1'b0, 8'd4);
    // zero-length transfer
    tbl[8]  = mk(1'b1, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA4, 1'b0, 1'b0, 1'b0, 8'd4);
    tbl[9]  = mk(1'b0, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0);
    tbl[10] = mk(1'b0, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    // restart pulses during RUN must be ignored
    tbl[11] = mk(1'b1, 8'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    tbl[12] = mk(1'b1, 8'd7, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0);
    tbl[13] = mk(1'b0, 8'd0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 8'd0);
    tbl[14] = mk(1'b1, 8'd9, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 8'd0);
    tbl[15] = mk(1'b0, 8'd0, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 8'd1);
    tbl[16] = mk(1'b0, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b1, 8'd2);
    tbl[17] = mk(1'b0, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0, 8'd2);

    // Reset state
    @(negedge clk_i); #1;
    chk("reset_outputs", {outs(), 32'd0} | {32'd0, stall_cnt_o}, 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // Vector table
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_i);
      start_i = tbl[i].start; len_i = tbl[i].len; inp_valid_i = tbl[i].iv;
      inp_data_i = tbl[i].id; oup_ready_i = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {43'd0, tbl[i].e_irdy, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_last,
           tbl[i].e_done, tbl[i].e_busy, tbl[i].e_cnt});
    end

    // len=3 with valid held for 6 cycles: exactly 3 upstream handshakes
    @(negedge clk_i);
    start_i = 1'b1; len_i = 8'd3; inp_valid_i = 1'b0; oup_ready_i = 1'b1;
    up = 0; ndone = 0;
    @(negedge clk_i); start_i = 1'b0; inp_valid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      inp_data_i = 8'hC0 + 8'(up);
      #1;
      if (up == 3) chk("len3_ready_low", {63'd0, inp_ready_o}, 64'd0);
      if (inp_valid_i && inp_ready_o) up++;
      if (done_o) ndone++;
      @(negedge clk_i);
    end
    inp_valid_i = 1'b0;
    chk("len3_handshakes", 64'(up), 64'd3);
    chk("len3_done_pulses", 64'(ndone), 64'd1);

    // len=5 with oup_ready pattern 1,0,0 repeating
    @(negedge clk_i);
    start_i = 1'b1; len_i = 8'd5; inp_valid_i = 1'b0; oup_ready_i = 1'b0;
    up = 0; dn = 0; seen = 1'b0;
    @(negedge clk_i); start_i = 1'b0; inp_valid_i = 1'b1;
    for (int k = 1; k <= 40 && !seen; k++) begin
      oup_ready_i = ((k - 1) % 3 == 0);
      inp_data_i  = 8'hD0 + 8'(up);
      #1;
      if (oup_valid_o) chk($sformatf("stall_data_k%0d", k), 64'(oup_data_o), 64'(8'hD0 + 8'(dn)));
      if (done_o) begin
        seen = 1'b1;
        `ifdef XDMA_BEAT_TRACKER_STALL_CNT_EN
        exp_stall = 32'd10;
        `else
        exp_stall = 32'd0;
        `endif
        chk("stall_cnt", 64'(stall_cnt_o), 64'(exp_stall));
        chk("stall_done_cycle", 64'(k), 64'd17);
      end
      if (inp_valid_i && inp_ready_o) up++;
      if (oup_valid_o && oup_ready_i) dn++;
      @(negedge clk_i);
    end
    inp_valid_i = 1'b0; oup_ready_i = 1'b1;
    chk("stall_done_seen", {63'd0, seen}, 64'd1);
    chk("stall_beats_out", 64'(dn), 64'd5);

    // len=8, reset after the third output handshake
    @(negedge clk_i);
    start_i = 1'b1; len_i = 8'd8; inp_valid_i = 1'b0; oup_ready_i = 1'b1;
    up = 0; dn = 0;
    @(negedge clk_i); start_i = 1'b0; inp_valid_i = 1'b1;
    for (int k = 0; k < 20 && dn < 3; k++) begin
      inp_data_i = 8'hE0 + 8'(up);
      #1;
      if (inp_valid_i && inp_ready_o) up++;
      if (oup_valid_o && oup_ready_i) dn++;
      if (dn < 3) @(negedge clk_i);
    end
    chk("rst_pre_beats", 64'(dn), 64'd3);
    @(posedge clk_i); #1;
    rst_ni = 1'b0; #1;
    chk("rst_mid_outputs", {outs(), 32'd0} | {32'd0, stall_cnt_o}, 64'd0);
    @(negedge clk_i); rst_ni = 1'b1; inp_valid_i = 1'b0;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (done_o || busy_o) ndone++;
      @(negedge clk_i);
    end
    chk("rst_no_done", 64'(ndone), 64'd0);

    // len=2 after the reset completes normally
    start_i = 1'b1; len_i = 8'd2; up = 0; seen = 1'b0;
    @(negedge clk_i); start_i = 1'b0; inp_valid_i = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      inp_data_i = 8'hF0 + 8'(up);
      #1;
      if (done_o) begin
        seen = 1'b1;
        chk("post_rst_cnt", 64'(beat_cnt_o), 64'd2);
        chk("post_rst_data", 64'(oup_data_o), 64'hF1);
      end
      if (inp_valid_i && inp_ready_o) up++;
      @(negedge clk_i);
    end
    inp_valid_i = 1'b0;
    chk("post_rst_done", {63'd0, seen}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
